// File: rtl/snake_move_ctrl_if.sv
// Command side of the snake move controller: move/grow requests,
// body colour and the idle handshake back to the requester.
interface snake_move_ctrl_if #(
    parameter int COL_W = 3
);
    logic             go;
    logic             grow;
    logic             ready;
    logic [COL_W-1:0] colour_in;

    modport master (
        output go,
        output grow,
        output colour_in,
        input  ready
    );

    modport slave (
        input  go,
        input  grow,
        input  colour_in,
        output ready
    );
endinterface

// File: rtl/snake_move_ctrl.sv
// Snake move controller: sequences the segment-shift datapath, draws
// every segment as a BLK x BLK block and erases or keeps the old tail.
module snake_move_ctrl #(
    parameter int               LEN_W     = 11,
    parameter int               INIT_LEN  = 3,
    parameter int               MAX_LEN   = 1024,
    parameter int               BLK       = 2,
    parameter int               COL_W     = 3,
    parameter logic [COL_W-1:0] HEAD_COL  = 3'b100,
    parameter logic [COL_W-1:0] ERASE_COL = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    snake_move_ctrl_if.slave         bus,
    output logic                     ld_head,
    output logic                     ld_def,
    output logic                     update_head,
    output logic                     ld_head_prev,
    output logic                     ld_q_curr,
    output logic                     ld_prev_q,
    output logic                     ld_curr_prev,
    output logic                     ld_append,
    output logic                     inc_address,
    output logic                     rst_address,
    output logic                     draw_q,
    output logic                     draw_curr,
    output logic                     plot,
    output logic [$clog2(BLK)-1:0]   px_x,
    output logic [$clog2(BLK)-1:0]   px_y,
    output logic [COL_W-1:0]         colour_out,
    output logic [LEN_W-1:0]         length
);

    typedef enum logic [3:0] {
        INIT_HEAD,
        INIT_DEF,
        RESET_CNT,
        DRAW_SEG,
        INC_CNT,
        IDLE,
        UPDATE_HEAD,
        LD_HEAD_PREV,
        LD_Q_CURR,
        LD_PREV_Q,
        LD_CURR_PREV,
        GROW,
        ERASE_TAIL
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] seg_cnt;
    logic             grow_pend;

    logic seg_inc;
    logic seg_clr;
    logic px_step;
    logic px_clr;
    logic len_inc;
    logic gp_clr;

    logic seg_last;
    logic seg_more;
    logic px_end;
    logic len_room;

    assign seg_last = (seg_cnt == length - 1'b1);
    assign seg_more = (seg_cnt < length - 1'b1);
    assign px_end   = (&px_x) && (&px_y);
    assign len_room = (length < LEN_W'(MAX_LEN));

    assign bus.ready = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT_HEAD;
            seg_cnt   <= '0;
            px_x      <= '0;
            px_y      <= '0;
            grow_pend <= 1'b0;
            length    <= LEN_W'(INIT_LEN);
        end else begin
            state <= state_nxt;
            if (seg_clr)
                seg_cnt <= '0;
            else if (seg_inc)
                seg_cnt <= seg_cnt + 1'b1;
            if (px_clr) begin
                px_x <= '0;
                px_y <= '0;
            end else if (px_step) begin
                px_x <= px_x + 1'b1;
                if (&px_x)
                    px_y <= px_y + 1'b1;
            end
            if (len_inc)
                length <= length + 1'b1;
            // growth decided on the tail step wins over a late pulse
            if (gp_clr)
                grow_pend <= 1'b0;
            else if (bus.grow)
                grow_pend <= 1'b1;
        end
    end

    always_comb begin
        state_nxt    = state;
        ld_head      = 1'b0;
        ld_def       = 1'b0;
        update_head  = 1'b0;
        ld_head_prev = 1'b0;
        ld_q_curr    = 1'b0;
        ld_prev_q    = 1'b0;
        ld_curr_prev = 1'b0;
        ld_append    = 1'b0;
        inc_address  = 1'b0;
        rst_address  = 1'b0;
        draw_q       = 1'b0;
        draw_curr    = 1'b0;
        plot         = 1'b0;
        colour_out   = '0;
        seg_inc      = 1'b0;
        seg_clr      = 1'b0;
        px_step      = 1'b0;
        px_clr       = 1'b0;
        len_inc      = 1'b0;
        gp_clr       = 1'b0;
        unique case (state)
            INIT_HEAD: begin
                ld_head   = 1'b1;
                state_nxt = INIT_DEF;
            end
            INIT_DEF: begin
                ld_def      = 1'b1;
                inc_address = (seg_cnt != '0);
                seg_inc     = 1'b1;
                if (seg_last)
                    state_nxt = RESET_CNT;
            end
            RESET_CNT: begin
                rst_address = 1'b1;
                seg_clr     = 1'b1;
                px_clr      = 1'b1;
                state_nxt   = DRAW_SEG;
            end
            DRAW_SEG: begin
                draw_q     = 1'b1;
                plot       = 1'b1;
                colour_out = (seg_cnt == '0) ? HEAD_COL : bus.colour_in;
                px_step    = 1'b1;
                if (px_end)
                    state_nxt = INC_CNT;
            end
            INC_CNT: begin
                inc_address = 1'b1;
                seg_inc     = 1'b1;
                state_nxt   = seg_more ? DRAW_SEG : IDLE;
            end
            IDLE: begin
                seg_clr = 1'b1;
                px_clr  = 1'b1;
                if (bus.go)
                    state_nxt = UPDATE_HEAD;
            end
            UPDATE_HEAD: begin
                update_head = 1'b1;
                rst_address = 1'b1;
                state_nxt   = LD_HEAD_PREV;
            end
            LD_HEAD_PREV: begin
                ld_head_prev = 1'b1;
                state_nxt    = LD_Q_CURR;
            end
            LD_Q_CURR: begin
                ld_q_curr = 1'b1;
                state_nxt = LD_PREV_Q;
            end
            LD_PREV_Q: begin
                ld_prev_q = 1'b1;
                state_nxt = LD_CURR_PREV;
            end
            LD_CURR_PREV: begin
                ld_curr_prev = 1'b1;
                inc_address  = 1'b1;
                seg_inc      = 1'b1;
                if (seg_more)
                    state_nxt = LD_Q_CURR;
                else if (grow_pend && len_room)
                    state_nxt = GROW;
                else
                    state_nxt = ERASE_TAIL;
            end
            GROW: begin
                ld_append = 1'b1;
                len_inc   = 1'b1;
                gp_clr    = 1'b1;
                state_nxt = RESET_CNT;
            end
            ERASE_TAIL: begin
                draw_curr  = 1'b1;
                plot       = 1'b1;
                colour_out = ERASE_COL;
                px_step    = 1'b1;
                gp_clr     = 1'b1;
                if (px_end)
                    state_nxt = RESET_CNT;
            end
            default: state_nxt = INIT_HEAD;
        endcase
    end

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Directed bench for snake_move_ctrl: expected cycle-by-cycle state
// letters are written out per scenario and compared on the falling edge.
module tb_snake_move_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic rst_b;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    snake_move_ctrl_if #(.COL_W(3)) a_bus ();
    snake_move_ctrl_if #(.COL_W(3)) b_bus ();

    logic a_ld_head, a_ld_def, a_update_head, a_ld_head_prev;
    logic a_ld_q_curr, a_ld_prev_q, a_ld_curr_prev, a_ld_append;
    logic a_inc_address, a_rst_address, a_draw_q, a_draw_curr, a_plot;
    logic        a_px_x, a_px_y;
    logic [2:0]  a_col;
    logic [10:0] a_len;
    logic [13:0] a_vec;

    logic b_ld_head, b_ld_def, b_update_head, b_ld_head_prev;
    logic b_ld_q_curr, b_ld_prev_q, b_ld_curr_prev, b_ld_append;
    logic b_inc_address, b_rst_address, b_draw_q, b_draw_curr, b_plot;
    logic [1:0]  b_px_x, b_px_y;
    logic [2:0]  b_col;
    logic [10:0] b_len;
    logic [13:0] b_vec;

    assign a_vec = {a_ld_head, a_ld_def, a_update_head, a_ld_head_prev,
                    a_ld_q_curr, a_ld_prev_q, a_ld_curr_prev, a_ld_append,
                    a_inc_address, a_rst_address, a_draw_q, a_draw_curr,
                    a_plot, a_bus.ready};
    assign b_vec = {b_ld_head, b_ld_def, b_update_head, b_ld_head_prev,
                    b_ld_q_curr, b_ld_prev_q, b_ld_curr_prev, b_ld_append,
                    b_inc_address, b_rst_address, b_draw_q, b_draw_curr,
                    b_plot, b_bus.ready};

    snake_move_ctrl #(.MAX_LEN(4)) u_a (
        .clk          (clk),
        .rst          (rst),
        .bus          (a_bus),
        .ld_head      (a_ld_head),
        .ld_def       (a_ld_def),
        .update_head  (a_update_head),
        .ld_head_prev (a_ld_head_prev),
        .ld_q_curr    (a_ld_q_curr),
        .ld_prev_q    (a_ld_prev_q),
        .ld_curr_prev (a_ld_curr_prev),
        .ld_append    (a_ld_append),
        .inc_address  (a_inc_address),
        .rst_address  (a_rst_address),
        .draw_q       (a_draw_q),
        .draw_curr    (a_draw_curr),
        .plot         (a_plot),
        .px_x         (a_px_x),
        .px_y         (a_px_y),
        .colour_out   (a_col),
        .length       (a_len)
    );

    snake_move_ctrl #(.BLK(4)) u_b (
        .clk          (clk),
        .rst          (rst_b),
        .bus          (b_bus),
        .ld_head      (b_ld_head),
        .ld_def       (b_ld_def),
        .update_head  (b_update_head),
        .ld_head_prev (b_ld_head_prev),
        .ld_q_curr    (b_ld_q_curr),
        .ld_prev_q    (b_ld_prev_q),
        .ld_curr_prev (b_ld_curr_prev),
        .ld_append    (b_ld_append),
        .inc_address  (b_inc_address),
        .rst_address  (b_rst_address),
        .draw_q       (b_draw_q),
        .draw_curr    (b_draw_curr),
        .plot         (b_plot),
        .px_x         (b_px_x),
        .px_y         (b_px_y),
        .colour_out   (b_col),
        .length       (b_len)
    );

    // strobe pattern per state letter, msb ld_head .. lsb ready
    function automatic logic [13:0] vec_of(byte ch);
        logic [13:0] v;
        v = '0;
        case (ch)
            "H": v[13] = 1'b1;
            "f": v[12] = 1'b1;
            "F": begin v[12] = 1'b1; v[5] = 1'b1; end
            "R": v[4] = 1'b1;
            "D": begin v[3] = 1'b1; v[1] = 1'b1; end
            "I": v[5] = 1'b1;
            "W": v[0] = 1'b1;
            "U": begin v[11] = 1'b1; v[4] = 1'b1; end
            "L": v[10] = 1'b1;
            "Q": v[9] = 1'b1;
            "P": v[8] = 1'b1;
            "C": begin v[7] = 1'b1; v[5] = 1'b1; end
            "G": v[6] = 1'b1;
            "E": begin v[2] = 1'b1; v[1] = 1'b1; end
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [2:0] col_exp(byte ch, int seg,
                                           logic [2:0] cin);
        if (ch == "D")
            return (seg == 0) ? 3'b100 : cin;
        return 3'b000;
    endfunction

    function automatic string draws(int n, int blk);
        string s;
        s = "";
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < blk * blk; j++)
                s = {s, "D"};
            s = {s, "I"};
        end
        return {s, "W"};
    endfunction

    function automatic string shift(int n);
        string s;
        s = "UL";
        for (int k = 0; k < n; k++)
            s = {s, "QPC"};
        return s;
    endfunction

    function automatic string erase(int blk);
        string s;
        s = "";
        for (int j = 0; j < blk * blk; j++)
            s = {s, "E"};
        return {s, "R"};
    endfunction

    task automatic test_reset();
        rst   = 1'b1;
        rst_b = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (a_vec !== vec_of("H")) begin
            errors++;
            $display("FAIL reset_strobes got=%b exp=%b", a_vec, vec_of("H"));
        end
        checks++;
        if (a_len !== 11'd3 || a_col !== 3'd0) begin
            errors++;
            $display("FAIL reset_len_col got=%0d/%0d exp=3/0", a_len, a_col);
        end
        checks++;
        if (b_vec !== vec_of("H") || b_len !== 11'd3) begin
            errors++;
            $display("FAIL reset_b got=%b/%0d exp=%b/3",
                     b_vec, b_len, vec_of("H"));
        end
        rst   = 1'b0;
        rst_b = 1'b0;
    endtask

    task automatic test_init_draw();
        string s;
        byte   ch, pc;
        int    seg, p;
        s   = {"fFFR", draws(3, 2)};
        seg = 0;
        p   = 0;
        pc  = 0;
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            ch = s[i];
            if (ch != pc) p = 0;
            if (ch == "R") seg = 0;
            checks++;
            if (a_vec !== vec_of(ch)) begin
                errors++;
                $display("FAIL init_strobe cyc=%0d st=%c got=%b exp=%b",
                         i + 1, ch, a_vec, vec_of(ch));
            end
            checks++;
            if (a_col !== col_exp(ch, seg, a_bus.colour_in)) begin
                errors++;
                $display("FAIL init_colour cyc=%0d got=%0d exp=%0d",
                         i + 1, a_col, col_exp(ch, seg, a_bus.colour_in));
            end
            if (ch == "D" || ch == "E") begin
                checks++;
                if (a_px_x !== 1'(p % 2) || a_px_y !== 1'(p / 2)) begin
                    errors++;
                    $display("FAIL init_pixel cyc=%0d got=%0d,%0d exp=%0d,%0d",
                             i + 1, a_px_x, a_px_y, p % 2, p / 2);
                end
                p++;
            end
            if (ch == "I") seg++;
            pc = ch;
        end
    endtask

    task automatic test_move();
        string s;
        byte   ch, pc;
        int    seg, p;
        s   = {shift(3), erase(2), draws(3, 2)};
        seg = 0;
        p   = 0;
        pc  = 0;
        a_bus.go = 1'b1;
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            ch = s[i];
            if (ch != pc) p = 0;
            if (ch == "R") seg = 0;
            checks++;
            if (a_vec !== vec_of(ch)) begin
                errors++;
                $display("FAIL move_strobe cyc=%0d st=%c got=%b exp=%b",
                         i, ch, a_vec, vec_of(ch));
            end
            checks++;
            if (a_col !== col_exp(ch, seg, a_bus.colour_in)) begin
                errors++;
                $display("FAIL move_colour cyc=%0d got=%0d exp=%0d",
                         i, a_col, col_exp(ch, seg, a_bus.colour_in));
            end
            if (ch == "D" || ch == "E") begin
                checks++;
                if (a_px_x !== 1'(p % 2) || a_px_y !== 1'(p / 2)) begin
                    errors++;
                    $display("FAIL move_pixel cyc=%0d got=%0d,%0d exp=%0d,%0d",
                             i, a_px_x, a_px_y, p % 2, p / 2);
                end
                p++;
            end
            if (ch == "I") seg++;
            if (ch == "U") a_bus.go = 1'b0;
            pc = ch;
        end
        checks++;
        if (a_len !== 11'd3) begin
            errors++;
            $display("FAIL move_length got=%0d exp=3", a_len);
        end
    endtask

    task automatic test_grow();
        string s;
        byte   ch;
        int    seg;
        // two grow pulses during the redraw, then a move that grows
        s   = {shift(3), erase(2), draws(3, 2), shift(3), "GR", draws(4, 2)};
        seg = 0;
        a_bus.go = 1'b1;
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            ch = s[i];
            if (ch == "R") seg = 0;
            checks++;
            if (a_vec !== vec_of(ch)) begin
                errors++;
                $display("FAIL grow_strobe cyc=%0d st=%c got=%b exp=%b",
                         i, ch, a_vec, vec_of(ch));
            end
            checks++;
            if (a_col !== col_exp(ch, seg, a_bus.colour_in)) begin
                errors++;
                $display("FAIL grow_colour cyc=%0d got=%0d exp=%0d",
                         i, a_col, col_exp(ch, seg, a_bus.colour_in));
            end
            if (ch == "I") seg++;
            if (ch == "U") a_bus.go = 1'b0;
            if (ch == "W") a_bus.go = 1'b1;
            a_bus.grow = (i == 20 || i == 23);
        end
        a_bus.go = 1'b0;
        checks++;
        if (a_len !== 11'd4) begin
            errors++;
            $display("FAIL grow_length got=%0d exp=4", a_len);
        end
    endtask

    task automatic test_max_len();
        string s;
        byte   ch;
        s = {shift(4), erase(2), draws(4, 2)};
        a_bus.go   = 1'b1;
        a_bus.grow = 1'b1;
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            ch = s[i];
            checks++;
            if (a_vec !== vec_of(ch)) begin
                errors++;
                $display("FAIL max_strobe cyc=%0d st=%c got=%b exp=%b",
                         i, ch, a_vec, vec_of(ch));
            end
            if (ch == "U") begin
                a_bus.go   = 1'b0;
                a_bus.grow = 1'b0;
            end
        end
        checks++;
        if (a_len !== 11'd4) begin
            errors++;
            $display("FAIL max_length got=%0d exp=4", a_len);
        end
    endtask

    task automatic test_reset_mid_draw();
        string s;
        byte   ch;
        s = {shift(4), erase(2), draws(4, 2)};
        a_bus.go = 1'b1;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            ch = s[i];
            checks++;
            if (a_vec !== vec_of(ch)) begin
                errors++;
                $display("FAIL rmid_strobe cyc=%0d st=%c got=%b exp=%b",
                         i, ch, a_vec, vec_of(ch));
            end
            if (ch == "U") a_bus.go = 1'b0;
            a_bus.grow = (i == 20);
        end
        rst      = 1'b1;
        a_bus.go = 1'b1;
        @(negedge clk);
        checks++;
        if (a_vec !== vec_of("H") || a_len !== 11'd3 || a_col !== 3'd0) begin
            errors++;
            $display("FAIL rmid_reset got=%b/%0d/%0d exp=%b/3/0",
                     a_vec, a_len, a_col, vec_of("H"));
        end
        rst = 1'b0;
        // go stays high through the redraw; the move runs with no growth
        s = {"fFFR", draws(3, 2), shift(3), erase(2), draws(3, 2)};
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            ch = s[i];
            checks++;
            if (a_vec !== vec_of(ch)) begin
                errors++;
                $display("FAIL rmid_after cyc=%0d st=%c got=%b exp=%b",
                         i, ch, a_vec, vec_of(ch));
            end
            if (ch == "U") a_bus.go = 1'b0;
        end
        checks++;
        if (a_len !== 11'd3) begin
            errors++;
            $display("FAIL rmid_length got=%0d exp=3", a_len);
        end
    endtask

    task automatic test_blk4();
        string s;
        byte   ch, pc;
        int    seg, p;
        for (int k = 0; k < 400 && b_bus.ready !== 1'b1; k++)
            @(negedge clk);
        checks++;
        if (b_bus.ready !== 1'b1) begin
            errors++;
            $display("FAIL blk4_ready got=%b exp=1", b_bus.ready);
        end
        s   = {shift(3), erase(4), draws(3, 4)};
        seg = 0;
        p   = 0;
        pc  = 0;
        b_bus.go = 1'b1;
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            ch = s[i];
            if (ch != pc) p = 0;
            if (ch == "R") seg = 0;
            checks++;
            if (b_vec !== vec_of(ch)) begin
                errors++;
                $display("FAIL blk4_strobe cyc=%0d st=%c got=%b exp=%b",
                         i, ch, b_vec, vec_of(ch));
            end
            checks++;
            if (b_col !== col_exp(ch, seg, b_bus.colour_in)) begin
                errors++;
                $display("FAIL blk4_colour cyc=%0d got=%0d exp=%0d",
                         i, b_col, col_exp(ch, seg, b_bus.colour_in));
            end
            if (ch == "D" || ch == "E") begin
                checks++;
                if (b_px_x !== 2'(p % 4) || b_px_y !== 2'(p / 4)) begin
                    errors++;
                    $display("FAIL blk4_pixel cyc=%0d got=%0d,%0d exp=%0d,%0d",
                             i, b_px_x, b_px_y, p % 4, p / 4);
                end
                p++;
            end
            if (ch == "I") seg++;
            if (ch == "U") b_bus.go = 1'b0;
            pc = ch;
        end
        checks++;
        if (b_len !== 11'd3) begin
            errors++;
            $display("FAIL blk4_length got=%0d exp=3", b_len);
        end
    endtask

    initial begin
        rst             = 1'b1;
        rst_b           = 1'b1;
        a_bus.go        = 1'b0;
        a_bus.grow      = 1'b0;
        a_bus.colour_in = 3'b011;
        b_bus.go        = 1'b0;
        b_bus.grow      = 1'b0;
        b_bus.colour_in = 3'b010;
        test_reset();
        test_init_draw();
        test_move();
        test_grow();
        test_max_len();
        test_reset_mid_draw();
        test_blk4();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

endmodule
